// File: rtl/instr_fetch_buf_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package instr_fetch_buf_pkg;

    localparam int IFB_WIDTH = 32;

    // RISC-V canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [IFB_WIDTH-1:0] instr;
        logic [IFB_WIDTH-1:0] pc;
        logic                 misalign;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_buf_if.sv
// Fetch buffer signal bundle: pc register side, imem side and decode side.
// master = fetch buffer, slave = surrounding pipeline / memory.
interface instr_fetch_buf_if
    import instr_fetch_buf_pkg::*;
#(
    parameter int WIDTH = IFB_WIDTH
);
    logic [WIDTH-1:0] pc_i;
    logic             pc_adv;
    logic             flush;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             instr_misalign;

    modport master (
        input  pc_i, flush, imem_ack, imem_rvalid, imem_rdata, instr_ready,
        output pc_adv, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_misalign
    );

    modport slave (
        output pc_i, flush, imem_ack, imem_rvalid, imem_rdata, instr_ready,
        input  pc_adv, imem_req, imem_addr, instr_valid, instr, instr_pc, instr_misalign
    );

endinterface

// File: rtl/instr_fetch_buf_sync_fifo.sv
// Small synchronous FIFO with synchronous clear. Head data reads 0 when empty.
// Pointers wrap at DEPTH, so DEPTH need not be a power of two.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch_buf.sv
// Instruction fetch buffer: issues in-order imem reads from pc_i under a
// credit rule, pairs returned data with its pc and queues it toward decode.
// A flush clears the buffer and drops every response still in flight.
// Optional build macro FETCH_MISALIGN_CHK_EN: a misaligned pc produces a NOP
// entry flagged instr_misalign instead of a memory request, then stalls
// fetch until the next flush.
//
// state    | meaning
// ST_RUN   | fetching normally under the credit rule
// ST_STALL | misaligned pc was seen; no requests until flush
module instr_fetch_buf
    import instr_fetch_buf_pkg::*;
#(
    parameter int WIDTH   = IFB_WIDTH,
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 2
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_buf_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
        logic             misalign;
    } entry_t;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic             misalign;
    } flight_t;

    fetch_state_e  state;
    fetch_state_e  state_nxt;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] out_nxt;
    logic [OW-1:0] discard;
    logic [OW-1:0] disc_nxt;
    logic [CW-1:0] fifo_count;
    logic [OW-1:0] q_count;
    logic [15:0]   occ;

    logic    credit;
    logic    mis_pc;
    logic    mis_take;
    logic    issue;
    logic    resp_any;
    logic    resp_take;
    logic    head_mis;
    logic    q_push;
    logic    q_pop;
    logic    f_push;
    logic    f_pop;
    flight_t q_din;
    flight_t q_dout;
    entry_t  f_din;
    entry_t  f_dout;

`ifdef FETCH_MISALIGN_CHK_EN
    assign mis_pc = (bus.pc_i[1:0] != 2'b00);
`else
    assign mis_pc = 1'b0;
`endif

    // Credits count outstanding requests (including ones to be discarded)
    // plus buffered entries, so the FIFO can never overflow. Gated by rst so
    // the request drops immediately on an asynchronous reset.
    assign occ       = 16'(outstanding) + 16'(fifo_count);
    assign credit    = rst && !bus.flush && (state == ST_RUN)
                       && (occ < 16'(DEPTH)) && (outstanding < OW'(MAX_OUT));
    assign mis_take  = credit && mis_pc;
    assign issue     = bus.imem_req && bus.imem_ack;

    assign bus.imem_req  = credit && !mis_pc;
    assign bus.imem_addr = bus.pc_i;
    assign bus.pc_adv    = issue;

    // Responses of pre-flush requests are dropped without touching the
    // in-flight queue: it was cleared by the flush and now holds only
    // post-flush requests.
    assign resp_any  = bus.imem_rvalid && (outstanding != '0);
    assign resp_take = bus.imem_rvalid && (discard == '0);
    assign head_mis  = (q_count != '0) && q_dout.misalign;

    assign q_push = issue || mis_take;
    assign q_din  = {bus.pc_i, mis_take};
    assign q_pop  = resp_take || head_mis;

    assign f_push = !bus.flush && (resp_take || head_mis);
    assign f_din  = resp_take ? {bus.imem_rdata, q_dout.pc, 1'b0}
                              : {WIDTH'(NOP_INSTR), q_dout.pc, 1'b1};
    assign f_pop  = bus.instr_valid && bus.instr_ready;

    assign bus.instr_valid = (fifo_count != '0);
    assign bus.instr          = f_dout.instr;
    assign bus.instr_pc       = f_dout.pc;
    assign bus.instr_misalign = f_dout.misalign;

    sync_fifo #(.W($bits(flight_t)), .DEPTH(MAX_OUT)) u_flight_q (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_dout),
        .count (q_count)
    );

    sync_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush),
        .push  (f_push),
        .din   (f_din),
        .pop   (f_pop),
        .dout  (f_dout),
        .count (fifo_count)
    );

    // next state plus outstanding/discard bookkeeping
    always_comb begin
        state_nxt = state;
        out_nxt   = outstanding;
        disc_nxt  = discard;
        if (bus.flush) begin
            state_nxt = ST_RUN;
            out_nxt   = outstanding - OW'(resp_any);
            disc_nxt  = outstanding - OW'(resp_any);
        end else begin
            if (mis_take) state_nxt = ST_STALL;
            out_nxt = outstanding + OW'(issue) - OW'(resp_any);
            if (bus.imem_rvalid && (discard != '0)) disc_nxt = discard - OW'(1);
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RUN;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            discard     <= disc_nxt;
        end
    end

    a_rvalid_legal: assert property (@(posedge clk) disable iff (!rst)
        bus.imem_rvalid |-> (outstanding != '0));
    a_fifo_no_ovf: assert property (@(posedge clk) disable iff (!rst)
        (f_push && !bus.flush) |-> ((fifo_count < CW'(DEPTH)) || f_pop));
    a_queue_no_ovf: assert property (@(posedge clk) disable iff (!rst)
        (q_push && !bus.flush) |-> ((q_count < OW'(MAX_OUT)) || q_pop));

endmodule
